// File: rtl/fp_to_int_unit_sp_pkg.sv
// Shared types for the FP-to-integer unit: flopoco operand layout, op codes,
// rounding modes and FCLASS bit positions.
package fp_to_int_unit_sp_pkg;

  localparam int unsigned ID_W = 4;
  typedef logic [ID_W-1:0] id_t;

  localparam logic [1:0] EXN_ZERO   = 2'b00;
  localparam logic [1:0] EXN_NORMAL = 2'b01;
  localparam logic [1:0] EXN_INF    = 2'b10;
  localparam logic [1:0] EXN_NAN    = 2'b11;

  typedef struct packed {
    logic [1:0]  exn;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } flopoco_t;

  typedef enum logic [1:0] {
    FPCVT_TO_I_OP,
    FPCVT_TO_U_OP,
    FPMV_TO_X_OP,
    FPCLASS_OP
  } fp_to_int_op_t;

  typedef struct packed {
    flopoco_t      rs1;
    fp_to_int_op_t op;
    logic [2:0]    rm;
  } fp_to_int_inputs_t;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int unsigned FCLASS_NEG_INF  = 0;
  localparam int unsigned FCLASS_NEG_NORM = 1;
  localparam int unsigned FCLASS_NEG_ZERO = 3;
  localparam int unsigned FCLASS_POS_ZERO = 4;
  localparam int unsigned FCLASS_POS_NORM = 6;
  localparam int unsigned FCLASS_POS_INF  = 7;
  localparam int unsigned FCLASS_QNAN     = 9;

  function automatic logic [31:0] fclass_mask(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/fp_to_int_unit_sp_if.sv
// Issue and writeback handshake interfaces used by the FP-to-integer unit.
interface unit_issue_interface;
  import fp_to_int_unit_sp_pkg::*;
  logic ready;
  logic new_request;
  id_t  id;
  modport unit (output ready, input new_request, input id);
  modport decode (input ready, output new_request, output id);
endinterface

interface unit_writeback_interface;
  import fp_to_int_unit_sp_pkg::*;
  logic        done;
  logic [31:0] rd;
  id_t         id;
  logic        ack;
  modport unit (output done, output rd, output id, input ack);
  modport wb (input done, input rd, input id, output ack);
endinterface

// File: rtl/fp_to_int_unit_sp_round_sat.sv
// Combinational rounding and saturation of an aligned magnitude to a 32-bit
// signed/unsigned integer. Flag outputs exist only with FP_CVT_FFLAGS_EN.
module fp_round_sat_sp
  import fp_to_int_unit_sp_pkg::*;
(
  input  logic [32:0] mag,
  input  logic        guard,
  input  logic        sticky,
  input  logic        sign,
  input  logic        ovf,
  input  logic [1:0]  exn,
  input  logic [2:0]  rm,
  input  logic        to_unsigned,
  output logic [31:0] result
`ifdef FP_CVT_FFLAGS_EN
  ,
  output logic        nv,
  output logic        nx
`endif
);

  logic        inexact;
  logic        inc;
  logic [32:0] rounded;
  logic [31:0] sat_hi;
  logic [31:0] sat_lo;
  logic        invalid;

  always_comb begin
    inexact = guard | sticky;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mag[0]);
    endcase
    rounded = mag + {32'd0, inc};

    sat_hi = to_unsigned ? '1 : 32'h7FFF_FFFF;
    sat_lo = to_unsigned ? '0 : 32'h8000_0000;

    // Range check uses the full 33-bit rounded value so a carry out of the
    // increment still saturates instead of wrapping.
    case (exn)
      EXN_INF, EXN_NAN: invalid = 1'b1;
      EXN_NORMAL: begin
        if (ovf)
          invalid = 1'b1;
        else if (to_unsigned)
          invalid = sign ? (rounded != '0) : rounded[32];
        else
          invalid = sign ? (rounded > 33'h0_8000_0000) : (rounded > 33'h0_7FFF_FFFF);
      end
      default: invalid = 1'b0;
    endcase

    if (invalid)
      result = ((exn == EXN_NAN) || !sign) ? sat_hi : sat_lo;
    else if (sign)
      result = (~rounded[31:0]) + 32'd1;
    else
      result = rounded[31:0];
  end

`ifdef FP_CVT_FFLAGS_EN
  assign nv = invalid;
  assign nx = inexact & ~invalid;
`endif

endmodule

// File: rtl/fp_to_int_unit_sp.sv
// Two-stage FCVT.W.S / FCVT.WU.S / FMV.X.W / FCLASS.S unit on flopoco operands.
// Define FP_CVT_FFLAGS_EN to add the registered fflags output.
module fp_to_int_unit_sp
  import fp_to_int_unit_sp_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned XLEN   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  fp_to_int_inputs_t           inputs,
  unit_issue_interface.unit           issue,
  unit_writeback_interface.unit       wb
`ifdef FP_CVT_FFLAGS_EN
  ,
  output logic [4:0]                  fflags
`endif
);

  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

  typedef struct packed {
    id_t             id;
    fp_to_int_op_t   op;
    logic [2:0]      rm;
    logic            sign;
    logic [1:0]      exn;
    logic [32:0]     mag;
    logic            guard;
    logic            sticky;
    logic            ovf;
    logic [XLEN-1:0] misc;
  } s1_t;

  typedef struct packed {
    id_t             id;
    logic [XLEN-1:0] rd;
`ifdef FP_CVT_FFLAGS_EN
    logic            nv;
    logic            nx;
`endif
  } s2_t;

  logic v1_q, v1_d, v2_q, v2_d;
  s1_t  s1_q, s1_d, s1_new;
  s2_t  s2_q, s2_d, s2_new;
  logic adv1, adv2;

  logic signed [9:0] exp_unb;
  logic [55:0]       shifted;
  logic [XLEN-1:0]   fmv_val;
  logic [XLEN-1:0]   cls_val;

  logic [31:0] cvt_result;
  logic        is_cvt;
`ifdef FP_CVT_FFLAGS_EN
  logic        cvt_nv;
  logic        cvt_nx;
`endif

  always_comb begin
    adv2 = !v2_q || wb.ack;
    adv1 = !v1_q || adv2;
  end

  assign issue.ready = adv1;

  // Stage 1: alignment into integer magnitude + guard/sticky, and the
  // non-arithmetic results (FMV/FCLASS), which need no second stage work.
  always_comb begin
    exp_unb = $signed({2'b00, inputs.rs1.exp}) - $signed(10'(BIAS));
    shifted = {32'd0, 1'b1, inputs.rs1.frac} << exp_unb[4:0];

    s1_new        = '0;
    s1_new.id     = issue.id;
    s1_new.op     = inputs.op;
    s1_new.rm     = inputs.rm;
    s1_new.sign   = inputs.rs1.sign;
    s1_new.exn    = inputs.rs1.exn;

    if (inputs.rs1.exn == EXN_NORMAL) begin
      if (exp_unb < 10'sd0) begin
        s1_new.guard  = (exp_unb == -10'sd1);
        s1_new.sticky = (exp_unb == -10'sd1) ? (|inputs.rs1.frac) : 1'b1;
      end else if (exp_unb > 10'sd31) begin
        s1_new.ovf = 1'b1;
      end else begin
        s1_new.mag    = shifted[FRAC_W+32:FRAC_W];
        s1_new.guard  = shifted[FRAC_W-1];
        s1_new.sticky = |shifted[FRAC_W-2:0];
      end
    end

    case (inputs.rs1.exn)
      EXN_ZERO: begin
        fmv_val = {inputs.rs1.sign, 31'd0};
        cls_val = fclass_mask(inputs.rs1.sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO);
      end
      EXN_NORMAL: begin
        fmv_val = {inputs.rs1.sign, inputs.rs1.exp, inputs.rs1.frac};
        cls_val = fclass_mask(inputs.rs1.sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM);
      end
      EXN_INF: begin
        fmv_val = {inputs.rs1.sign, 8'hFF, 23'd0};
        cls_val = fclass_mask(inputs.rs1.sign ? FCLASS_NEG_INF : FCLASS_POS_INF);
      end
      default: begin
        fmv_val = 32'h7FC0_0000;
        cls_val = fclass_mask(FCLASS_QNAN);
      end
    endcase
    s1_new.misc = (inputs.op == FPCLASS_OP) ? cls_val : fmv_val;

    v1_d = adv1 ? issue.new_request : v1_q;
    s1_d = adv1 ? s1_new : s1_q;
  end

  fp_round_sat_sp u_round_sat (
    .mag         (s1_q.mag),
    .guard       (s1_q.guard),
    .sticky      (s1_q.sticky),
    .sign        (s1_q.sign),
    .ovf         (s1_q.ovf),
    .exn         (s1_q.exn),
    .rm          (s1_q.rm),
    .to_unsigned (s1_q.op == FPCVT_TO_U_OP),
    .result      (cvt_result)
`ifdef FP_CVT_FFLAGS_EN
    ,
    .nv          (cvt_nv),
    .nx          (cvt_nx)
`endif
  );

  always_comb begin
    is_cvt    = (s1_q.op == FPCVT_TO_I_OP) || (s1_q.op == FPCVT_TO_U_OP);
    s2_new    = '0;
    s2_new.id = s1_q.id;
    s2_new.rd = is_cvt ? cvt_result : s1_q.misc;
`ifdef FP_CVT_FFLAGS_EN
    s2_new.nv = is_cvt & cvt_nv;
    s2_new.nx = is_cvt & cvt_nx;
`endif
    v2_d = adv2 ? v1_q : v2_q;
    s2_d = adv2 ? s2_new : s2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign wb.done = v2_q;
  assign wb.rd   = s2_q.rd;
  assign wb.id   = s2_q.id;
`ifdef FP_CVT_FFLAGS_EN
  assign fflags  = {s2_q.nv, 3'b000, s2_q.nx};
`endif

endmodule

// File: tb/tb_fp_to_int_unit_sp.sv
// Scoreboard bench for fp_to_int_unit_sp: expected results queued at
// acceptance, compared in order as the unit retires them.
module tb_fp_to_int_unit_sp;
  import fp_to_int_unit_sp_pkg::*;

  logic clk;
  logic rst_n;
  fp_to_int_inputs_t inputs;
`ifdef FP_CVT_FFLAGS_EN
  logic [4:0] fflags;
`endif

  unit_issue_interface     issue_if();
  unit_writeback_interface wb_if();

  fp_to_int_unit_sp #(.EXP_W(8), .FRAC_W(23), .XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inputs (inputs),
    .issue  (issue_if),
    .wb     (wb_if)
`ifdef FP_CVT_FFLAGS_EN
    ,
    .fflags (fflags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    id_t         id;
    logic        nv;
    logic        nx;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  id_t  next_id = '0;

  function automatic flopoco_t mk(input logic [1:0] exn, input logic s,
                                  input logic [7:0] e, input logic [22:0] f);
    return {exn, s, e, f};
  endfunction

  task automatic issue_op(input flopoco_t a, input fp_to_int_op_t op, input logic [2:0] rm,
                          input logic [31:0] rd, input logic nv, input logic nx, input int tag);
    exp_t e;
    int   n = 0;
    inputs.rs1 = a;
    inputs.op  = op;
    inputs.rm  = rm;
    issue_if.id = next_id;
    issue_if.new_request = 1'b1;
    @(negedge clk);
    while (!issue_if.ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!issue_if.ready) begin
      total++; bad++;
      $display("FAIL issue_timeout tag=%0d ready=%b required=1", tag, issue_if.ready);
    end else begin
      e.rd = rd; e.id = next_id; e.nv = nv; e.nx = nx; e.tag = tag;
      sb.push_back(e);
      next_id = next_id + 1'b1;
    end
    @(posedge clk); #1;
    issue_if.new_request = 1'b0;
  endtask

  task automatic monitor;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_if.done && wb_if.ack) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result rd=%h id=%0d required=none", wb_if.rd, wb_if.id);
        end else begin
          e = sb.pop_front();
          if (wb_if.rd !== e.rd || wb_if.id !== e.id) begin
            bad++;
            $display("FAIL result_tag%0d rd=%h id=%0d required rd=%h id=%0d",
                     e.tag, wb_if.rd, wb_if.id, e.rd, e.id);
          end
`ifdef FP_CVT_FFLAGS_EN
          total++;
          if (fflags !== {e.nv, 3'b000, e.nx}) begin
            bad++;
            $display("FAIL fflags_tag%0d got=%b required=%b", e.tag, fflags, {e.nv, 3'b000, e.nx});
          end
`endif
        end
      end
    end
  endtask

  task automatic wait_drain;
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (wb_if.done !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b required=0", wb_if.done);
    end
    total++;
    if (issue_if.ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b required=1", issue_if.ready);
    end
  endtask

  task automatic test_rounding;
    flopoco_t p25 = mk(EXN_NORMAL, 1'b0, 8'd128, 23'h200000);
    issue_op(p25, FPCVT_TO_I_OP, RM_RNE, 32'd2, 1'b0, 1'b1, 1);
    issue_op(p25, FPCVT_TO_I_OP, RM_RTZ, 32'd2, 1'b0, 1'b1, 2);
    issue_op(p25, FPCVT_TO_I_OP, RM_RUP, 32'd3, 1'b0, 1'b1, 3);
    issue_op(p25, FPCVT_TO_I_OP, RM_RDN, 32'd2, 1'b0, 1'b1, 4);
    issue_op(p25, FPCVT_TO_I_OP, RM_RMM, 32'd3, 1'b0, 1'b1, 5);
    issue_op(p25, FPCVT_TO_I_OP, 3'd7,   32'd2, 1'b0, 1'b1, 6);
    // 0.5 ties to even 0, 0.75 rounds to 1
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd126, 23'h0),      FPCVT_TO_I_OP, RM_RNE, 32'd0, 1'b0, 1'b1, 7);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd126, 23'h400000), FPCVT_TO_I_OP, RM_RNE, 32'd1, 1'b0, 1'b1, 8);
    wait_drain();
  endtask

  task automatic test_signed_sat;
    issue_op(mk(EXN_NORMAL, 1'b1, 8'd127, 23'h400000), FPCVT_TO_I_OP, RM_RNE, 32'hFFFF_FFFE, 1'b0, 1'b1, 10);
    issue_op(mk(EXN_NORMAL, 1'b1, 8'd158, 23'h0),      FPCVT_TO_I_OP, RM_RNE, 32'h8000_0000, 1'b0, 1'b0, 11);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd158, 23'h0),      FPCVT_TO_I_OP, RM_RNE, 32'h7FFF_FFFF, 1'b1, 1'b0, 12);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd157, 23'h7FFFFF), FPCVT_TO_I_OP, RM_RUP, 32'h7FFF_FF80, 1'b0, 1'b0, 13);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd158, 23'h000001), FPCVT_TO_I_OP, RM_RUP, 32'h7FFF_FFFF, 1'b1, 1'b0, 14);
    issue_op(mk(EXN_NORMAL, 1'b1, 8'd159, 23'h0),      FPCVT_TO_I_OP, RM_RNE, 32'h8000_0000, 1'b1, 1'b0, 15);
    issue_op(mk(EXN_NORMAL, 1'b1, 8'd125, 23'h0),      FPCVT_TO_I_OP, RM_RDN, 32'hFFFF_FFFF, 1'b0, 1'b1, 16);
    issue_op(mk(EXN_ZERO,   1'b1, 8'd0,   23'h0),      FPCVT_TO_I_OP, RM_RDN, 32'h0,         1'b0, 1'b0, 17);
    wait_drain();
  endtask

  task automatic test_unsigned_specials;
    issue_op(mk(EXN_NORMAL, 1'b1, 8'd125, 23'h0),      FPCVT_TO_U_OP, RM_RTZ, 32'h0,         1'b0, 1'b1, 20);
    issue_op(mk(EXN_NORMAL, 1'b1, 8'd125, 23'h0),      FPCVT_TO_U_OP, RM_RDN, 32'h0,         1'b1, 1'b0, 21);
    issue_op(mk(EXN_NORMAL, 1'b1, 8'd127, 23'h0),      FPCVT_TO_U_OP, RM_RNE, 32'h0,         1'b1, 1'b0, 22);
    issue_op(mk(EXN_NAN,    1'b0, 8'd0,   23'h0),      FPCVT_TO_U_OP, RM_RNE, 32'hFFFF_FFFF, 1'b1, 1'b0, 23);
    issue_op(mk(EXN_INF,    1'b1, 8'd0,   23'h0),      FPCVT_TO_I_OP, RM_RNE, 32'h8000_0000, 1'b1, 1'b0, 24);
    issue_op(mk(EXN_INF,    1'b0, 8'd0,   23'h0),      FPCVT_TO_U_OP, RM_RNE, 32'hFFFF_FFFF, 1'b1, 1'b0, 25);
    issue_op(mk(EXN_NAN,    1'b1, 8'd0,   23'h0),      FPCVT_TO_I_OP, RM_RNE, 32'h7FFF_FFFF, 1'b1, 1'b0, 26);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd158, 23'h7FFFFF), FPCVT_TO_U_OP, RM_RNE, 32'hFFFF_FF00, 1'b0, 1'b0, 27);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd159, 23'h0),      FPCVT_TO_U_OP, RM_RNE, 32'hFFFF_FFFF, 1'b1, 1'b0, 28);
    wait_drain();
  endtask

  task automatic test_fmv_fclass;
    issue_op(mk(EXN_NAN,    1'b0, 8'd3,   23'h12345), FPMV_TO_X_OP, RM_RNE, 32'h7FC0_0000, 1'b0, 1'b0, 30);
    issue_op(mk(EXN_ZERO,   1'b1, 8'd0,   23'h0),     FPMV_TO_X_OP, RM_RNE, 32'h8000_0000, 1'b0, 1'b0, 31);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd127, 23'h0),     FPMV_TO_X_OP, RM_RNE, 32'h3F80_0000, 1'b0, 1'b0, 32);
    issue_op(mk(EXN_INF,    1'b1, 8'd0,   23'h0),     FPMV_TO_X_OP, RM_RNE, 32'hFF80_0000, 1'b0, 1'b0, 33);
    issue_op(mk(EXN_INF,    1'b0, 8'd0,   23'h0),     FPCLASS_OP,   RM_RNE, 32'h080,       1'b0, 1'b0, 34);
    issue_op(mk(EXN_NORMAL, 1'b1, 8'd100, 23'h5),     FPCLASS_OP,   RM_RNE, 32'h002,       1'b0, 1'b0, 35);
    issue_op(mk(EXN_ZERO,   1'b0, 8'd0,   23'h0),     FPCLASS_OP,   RM_RNE, 32'h010,       1'b0, 1'b0, 36);
    issue_op(mk(EXN_NAN,    1'b1, 8'd0,   23'h0),     FPCLASS_OP,   RM_RNE, 32'h200,       1'b0, 1'b0, 37);
    wait_drain();
  endtask

  task automatic test_back_to_back;
    next_id = 4'd1;
    wb_if.ack = 1'b0;
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd127, 23'h0), FPCVT_TO_I_OP, RM_RNE, 32'd1, 1'b0, 1'b0, 40);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd128, 23'h0), FPCVT_TO_I_OP, RM_RNE, 32'd2, 1'b0, 1'b0, 41);
    inputs.rs1 = mk(EXN_NORMAL, 1'b0, 8'd128, 23'h400000);
    issue_if.id = 4'd3;
    issue_if.new_request = 1'b1;
    @(negedge clk);
    total++;
    if (issue_if.ready !== 1'b0) begin
      bad++; $display("FAIL bp_ready_low got=%b required=0", issue_if.ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      total++;
      if (wb_if.done !== 1'b1 || wb_if.rd !== 32'd1 || wb_if.id !== 4'd1) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d done=%b rd=%h id=%0d required done=1 rd=00000001 id=1",
                 i, wb_if.done, wb_if.rd, wb_if.id);
      end
    end
    @(posedge clk); #1;
    wb_if.ack = 1'b1;
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd128, 23'h400000), FPCVT_TO_I_OP, RM_RNE, 32'd3, 1'b0, 1'b0, 42);
    wait_drain();
  endtask

  task automatic test_reset_mid_op;
    wb_if.ack = 1'b0;
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd127, 23'h0), FPCVT_TO_I_OP, RM_RNE, 32'd1, 1'b0, 1'b0, 50);
    issue_op(mk(EXN_NORMAL, 1'b0, 8'd128, 23'h0), FPCVT_TO_I_OP, RM_RNE, 32'd2, 1'b0, 1'b0, 51);
    total++;
    if (wb_if.done !== 1'b1 || issue_if.ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_full done=%b ready=%b required done=1 ready=0", wb_if.done, issue_if.ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    total++;
    if (wb_if.done !== 1'b0 || issue_if.ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_after done=%b ready=%b required done=0 ready=1", wb_if.done, issue_if.ready);
    end
    wb_if.ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (wb_if.done !== 1'b0) begin
        bad++; $display("FAIL rst_mid_stale cycle=%0d done=%b required=0", i, wb_if.done);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inputs = '0;
    issue_if.new_request = 1'b0;
    issue_if.id = '0;
    wb_if.ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    test_rounding();
    test_signed_sat();
    test_unsigned_specials();
    test_fmv_fclass();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_to_int_unit_sp.md
Name: fp_to_int_unit_sp

Overview:
- Two-stage pipelined functional unit. Consumes single-precision operands held in the FP register file in flopoco format, as written by the short FP unit.
- Produces 32-bit integer-side results for FCVT.W.S, FCVT.WU.S, FMV.X.W and FCLASS.S.
- Sits beside the other FP units on the issue/writeback fabric. Handshakes through unit_issue_interface and unit_writeback_interface.

Parameters:
- EXP_W, 8, exponent width of flopoco operand (only default supported).
- FRAC_W, 23, fraction width of flopoco operand (only default supported).
- XLEN, 32, integer result width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- inputs  input  fp_to_int_inputs_t  fields:
  - rs1: flopoco_t, 34b: [33:32] exn 00 zero / 01 normal / 10 inf / 11 NaN; [31] sign; [30:23] exp, bias 127; [22:0] frac.
  - op: fp_to_int_op_t.
  - rm: 3b, resolved rounding mode.
- issue  interface  unit_issue_interface.unit  ready (out), new_request and id (in).
- wb  interface  unit_writeback_interface.unit  done, rd[31:0], id (out); ack (in).

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-low.
- Pipeline control:
  - adv2 = !v2 || wb.ack
  - adv1 = !v1 || adv2
  - issue.ready = adv1 (combinational)
- Stage registers:
  - On adv1: v1 <= issue.new_request; id/op/rm/rs1 captured.
  - On adv2: v2 <= v1; stage-1 results captured.
  - Registers hold when not advancing.
- Latency and throughput: result visible 2 cycles after acceptance; throughput 1/cycle; in-order.
- Outputs: wb.done = v2; wb.rd and wb.id are stable while v2 && !wb.ack.
- Reset (rst_n low at posedge):
  - v1 = v2 = 0, so wb.done = 0.
  - Data registers are don't-care.
  - In-flight ops are discarded, including mid-stall.
- Stage 1:
  - unbiased e = exp-127.
  - Align {1,frac} into a 33-bit integer magnitude plus guard and sticky bits.
  - e<0: magnitude 0; guard = (e==-1); sticky = remaining bits.
  - e>=32: flag overflow, shift skipped.
- Stage 2, round magnitude per rm:
  - RNE: round to nearest, ties to even.
  - RTZ: truncate.
  - RDN: increment if sign && inexact.
  - RUP: increment if !sign && inexact.
  - RMM: increment if guard.
  - rm 5-7: treated as RNE.
- Stage 2, apply sign, then saturate against the 33-bit rounded magnitude. Round-up overflow must saturate.
- W (signed):
  - Range [-2^31, 2^31-1]; out-of-range gives 0x7FFFFFFF or 0x80000000 by sign, NV.
  - -2^31 exactly is in range, no NV.
- WU (unsigned):
  - Range [0, 2^32-1].
  - Negative result that rounds to nonzero gives 0, NV. Negative rounding to 0 gives 0, NX only.
  - Overflow gives 0xFFFFFFFF, NV.
- Special operands for W/WU:
  - zero → 0, no flags.
  - +inf → max, NV.
  - -inf → min (W: 0x80000000, WU: 0), NV.
  - NaN → 0x7FFFFFFF (W) or 0xFFFFFFFF (WU), NV.
- NX: set when the result is inexact and NV is not set.
- FMV.X.W, pack to IEEE:
  - zero → {sign,31'b0}
  - normal → {sign,exp,frac}
  - inf → {sign,8'hFF,23'b0}
  - NaN → 0x7FC00000
- FCLASS: one-hot mask in bits [9:0], upper bits 0.
  - -inf bit0, -normal bit1, -zero bit3, +zero bit4, +normal bit6, +inf bit7, NaN bit9 (quiet).
  - Bits 2, 5, 8 are never set (no subnormals or sNaN in flopoco).
- FMV and FCLASS raise no flags.

Optional Feature:
- FP_CVT_FFLAGS_EN defined:
  - Adds output port fflags[4:0] = {NV,DZ,OF,UF,NX}, registered in stage 2 alongside rd.
  - DZ, OF and UF are always 0.
  - Valid when wb.done.
- FP_CVT_FFLAGS_EN undefined: port absent; flag logic removed; rd behaviour identical.

Decomposition:
- cva5_types gets:
  - fp_to_int_op_t enum {FPCVT_TO_I_OP, FPCVT_TO_U_OP, FPMV_TO_X_OP, FPCLASS_OP}
  - fp_to_int_inputs_t
  - rounding-mode localparams RM_RNE..RM_RMM
  - FCLASS bit-index constants
- flopoco_t and exn encodings are reused from the existing package.
- One sub-module: fp_round_sat_sp (stage-2 rounding plus saturation, combinational), reusable by a future FCVT.L unit.

Test Plan:
- Rounding of +2.5 (exn01, exp 128, frac 0x200000), W:
  - RNE→2, RTZ→2, RUP→3, RDN→2, RMM→3; NX set in all five.
- Signed rounding and saturation, W:
  - -1.5 RNE → 0xFFFFFFFE, NX.
  - -2^31 (exp 158, frac 0) → 0x80000000, no flags.
  - +2^31 → 0x7FFFFFFF, NV.
  - 2147483647.5-equivalent round-up case → 0x7FFFFFFF, NV.
- Unsigned and specials:
  - WU of -0.25 RTZ → 0, NX only.
  - WU of -1.0 → 0, NV.
  - WU of NaN → 0xFFFFFFFF, NV.
  - W of -inf → 0x80000000, NV.
- FMV/FCLASS:
  - FMV of NaN → 0x7FC00000.
  - FMV of -zero → 0x80000000.
  - FCLASS of +inf → 0x080.
  - FCLASS of -normal → 0x002.
- Backpressure:
  - Issue 3 back-to-back ops; hold wb.ack=0 for 4 cycles.
  - issue.ready drops once both stages are full.
  - rd/id held stable; results later drain in order with ids 1, 2, 3.
- Reset mid-operation: rst_n=0 for one cycle with v1=v2=1 → next cycle wb.done=0 and issue.ready=1; no stale result ever reaches wb.
